// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, with one transaction outstanding.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both sides request; default is LSU priority.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [BE_WIDTH-1:0]   lsu_be_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

  state_e                state_q, state_d;
  logic                  owner_lsu_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [BE_WIDTH-1:0]   mem_be_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic pick_lsu, pick_if, rsp_valid, arb_en, accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_lsu_q;

  // On contention the side not granted last time wins.
  assign pick_lsu = lsu_req_i && (!if_req_i || !last_lsu_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_lsu_q <= 1'b0;
    end else if (accept) begin
      last_lsu_q <= lsu_gnt_o;
    end
  end
`else
  assign pick_lsu = lsu_req_i;
`endif

  assign pick_if   = if_req_i && !pick_lsu;
  assign rsp_valid = (state_q == StWaitRsp) && mem_rvalid_i;
  // Re-arbitrating in the response cycle gives back-to-back issue every two cycles.
  assign arb_en    = (state_q == StIdle) || rsp_valid;
  assign lsu_gnt_o = arb_en && pick_lsu;
  assign if_gnt_o  = arb_en && pick_if;
  assign accept    = lsu_gnt_o || if_gnt_o;

  assign if_rvalid_o  = rsp_valid && !owner_lsu_q;
  assign lsu_rvalid_o = rsp_valid && owner_lsu_q;
  assign if_rdata_o   = mem_rdata_i;
  assign lsu_rdata_o  = mem_rdata_i;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StIssue;
      StIssue:   if (mem_gnt_i) state_d = StWaitRsp;
      StWaitRsp: if (mem_rvalid_i) state_d = accept ? StIssue : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      owner_lsu_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == StIssue);
      if (accept) begin
        owner_lsu_q <= lsu_gnt_o;
        mem_we_q    <= lsu_gnt_o ? lsu_we_i : 1'b0;
        mem_be_q    <= lsu_gnt_o ? lsu_be_i : {BE_WIDTH{1'b1}};
        mem_addr_q  <= lsu_gnt_o ? lsu_addr_i : if_addr_i;
        mem_wdata_q <= lsu_gnt_o ? lsu_wdata_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  mem_port_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_gnt_o    (if_gnt),
    .if_rvalid_o (if_rvalid),
    .if_rdata_o  (if_rdata),
    .lsu_req_i   (lsu_req),
    .lsu_we_i    (lsu_we),
    .lsu_be_i    (lsu_be),
    .lsu_addr_i  (lsu_addr),
    .lsu_wdata_i (lsu_wdata),
    .lsu_gnt_o   (lsu_gnt),
    .lsu_rvalid_o(lsu_rvalid),
    .lsu_rdata_o (lsu_rdata),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_gnt_i   (mem_gnt),
    .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0;
    lsu_req = 0; lsu_we = 0; lsu_be = 0; lsu_addr = 0; lsu_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk);
    settle();
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if ({if_gnt, lsu_gnt, if_rvalid, lsu_rvalid} !== 4'b0) begin
      n_fail++; $display("FAIL rst_gnt_rvalid: got %b want 0000", {if_gnt, lsu_gnt, if_rvalid, lsu_rvalid});
    end
    @(posedge clk); #1; rst = 0;
    settle();
    n_cmp++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'b0) begin
      n_fail++; $display("FAIL rst_mem_regs: got we=%b be=%h addr=%h wdata=%h want all 0", mem_we, mem_be, mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h100; mem_gnt = 1;
    settle();
    n_cmp++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt: got %b want 1", if_gnt); end
    tick(); if_req = 0;
    settle();
    n_cmp++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_fail++; $display("FAIL fetch_issue: got req=%b we=%b be=%h addr=%h want 1 0 f 00000100", mem_req, mem_we, mem_be, mem_addr);
    end
    tick(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    settle();
    n_cmp++; if ({if_rvalid, lsu_rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_rvalid: got if=%b lsu=%b want 1 0", if_rvalid, lsu_rvalid);
    end
    n_cmp++; if (if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_drop: got %b want 0", mem_req); end
    tick(); mem_rvalid = 0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    if_req = 1; if_addr = 32'h100;
    lsu_req = 1; lsu_we = 1; lsu_be = 4'h3; lsu_addr = 32'h2000; lsu_wdata = 32'h12345678;
    mem_gnt = 1;
    settle();
    n_cmp++; if ({lsu_gnt, if_gnt} !== 2'b10) begin n_fail++; $display("FAIL sim_first_gnt: got lsu=%b if=%b want 1 0", lsu_gnt, if_gnt); end
    tick(); lsu_req = 0;
    settle();
    n_cmp++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h2000, 32'h12345678}) begin
      n_fail++; $display("FAIL sim_lsu_issue: got req=%b we=%b be=%h addr=%h wdata=%h", mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    n_cmp++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL sim_if_wait: got %b want 0", if_gnt); end
    tick(); mem_rvalid = 1; mem_rdata = 32'h0000A5A5;
    settle();
    n_cmp++; if ({lsu_rvalid, if_rvalid, if_gnt} !== 3'b101) begin
      n_fail++; $display("FAIL sim_rsp_regrant: got lsu_rv=%b if_rv=%b if_gnt=%b want 1 0 1", lsu_rvalid, if_rvalid, if_gnt);
    end
    tick(); if_req = 0; mem_rvalid = 0;
    settle();
    n_cmp++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_fail++; $display("FAIL sim_if_issue: got req=%b we=%b be=%h addr=%h", mem_req, mem_we, mem_be, mem_addr);
    end
    tick(); mem_rvalid = 1; mem_rdata = 32'h0000CAFE;
    settle();
    n_cmp++; if ({if_rvalid, lsu_rvalid, if_rdata} !== {2'b10, 32'h0000CAFE}) begin
      n_fail++; $display("FAIL sim_if_rsp: got if_rv=%b lsu_rv=%b data=%h", if_rvalid, lsu_rvalid, if_rdata);
    end
    tick(); idle_inputs();
  endtask

  task automatic test_stall();
    if_req = 1; if_addr = 32'h300; mem_gnt = 0;
    settle();
    n_cmp++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL stall_gnt: got %b want 1", if_gnt); end
    tick(); if_req = 0;
    lsu_req = 1; lsu_we = 0; lsu_be = 4'hF; lsu_addr = 32'h500;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++; if ({mem_req, mem_addr, if_gnt, lsu_gnt} !== {1'b1, 32'h300, 2'b00}) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got req=%b addr=%h gnt=%b%b", i, mem_req, mem_addr, if_gnt, lsu_gnt);
      end
      tick();
    end
    mem_gnt = 1;
    settle();
    tick(); mem_rvalid = 1; mem_rdata = 32'h11112222;
    settle();
    n_cmp++; if ({if_rvalid, lsu_gnt} !== 2'b11) begin n_fail++; $display("FAIL stall_rsp: got if_rv=%b lsu_gnt=%b want 1 1", if_rvalid, lsu_gnt); end
    tick(); lsu_req = 0; mem_rvalid = 0;
    settle();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin n_fail++; $display("FAIL stall_lsu_issue: got req=%b addr=%h", mem_req, mem_addr); end
    tick(); mem_rvalid = 1;
    settle();
    n_cmp++; if ({lsu_rvalid, if_rvalid} !== 2'b10) begin n_fail++; $display("FAIL stall_lsu_rsp: got lsu=%b if=%b want 1 0", lsu_rvalid, if_rvalid); end
    tick(); idle_inputs();
  endtask

  task automatic test_spurious();
    mem_rvalid = 1; mem_rdata = 32'h00000BAD;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_cmp++; if ({if_rvalid, lsu_rvalid, mem_req} !== 3'b000) begin
        n_fail++; $display("FAIL spur_idle[%0d]: got if_rv=%b lsu_rv=%b req=%b want 000", i, if_rvalid, lsu_rvalid, mem_req);
      end
      tick();
    end
    mem_rvalid = 0; if_req = 1; if_addr = 32'h600; mem_gnt = 1;
    settle();
    n_cmp++; if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL spur_still_idle: got %b want 1", if_gnt); end
    tick(); if_req = 0; mem_rvalid = 1;
    settle();
    n_cmp++; if ({mem_req, if_rvalid} !== 2'b10) begin n_fail++; $display("FAIL spur_issue: got req=%b if_rv=%b want 1 0", mem_req, if_rvalid); end
    tick();
    settle();
    n_cmp++; if (if_rvalid !== 1'b1) begin n_fail++; $display("FAIL spur_real_rsp: got %b want 1", if_rvalid); end
    tick(); idle_inputs();
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 32'h400; mem_gnt = 1;
    settle();
    tick(); if_req = 0;
    settle();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL rmid_issue: got req=%b addr=%h", mem_req, mem_addr); end
    tick();
    settle();
    #1 rst = 1;
    #1;
    n_cmp++; if ({mem_req, mem_addr, if_rvalid, lsu_rvalid} !== 35'b0) begin
      n_fail++; $display("FAIL rmid_async: got req=%b addr=%h if_rv=%b lsu_rv=%b want 0", mem_req, mem_addr, if_rvalid, lsu_rvalid);
    end
    tick(); rst = 0;
    tick(); mem_rvalid = 1; mem_rdata = 32'h55555555;
    settle();
    n_cmp++; if ({if_rvalid, lsu_rvalid, mem_req} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_stale_rsp: got if_rv=%b lsu_rv=%b req=%b want 000", if_rvalid, lsu_rvalid, mem_req);
    end
    tick(); idle_inputs();
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    bit order[$];
    bit exp_order[4];
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
    apply_reset();
    if_req = 1; if_addr = 32'h700; lsu_req = 1; lsu_addr = 32'h800; lsu_be = 4'hF;
    mem_gnt = 1; mem_rvalid = 1;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (lsu_gnt) order.push_back(1'b1);
      if (if_gnt) order.push_back(1'b0);
      tick();
    end
    n_cmp++; if (order.size() !== 4) begin n_fail++; $display("FAIL rr_count: got %0d want 4", order.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) begin
        n_cmp++; if (order[i] !== exp_order[i]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got lsu=%b want lsu=%b", i, order[i], exp_order[i]);
        end
      end
    end
    if_req = 0; lsu_req = 0;
    repeat (3) tick();
    idle_inputs();
  endtask
`endif

  typedef struct {
    bit        valid;
    bit        lsu;
    bit        mem_acc;
    bit [31:0] addr;
    bit        we;
    bit [3:0]  be;
    bit [31:0] wdata;
  } txn_t;

  task automatic test_random();
    txn_t cur;
    bit   last_lsu, if_took, lsu_took, exp_req, resp, free, w_lsu, w_if;
    apply_reset();
    cur = '{default: 0};
    last_lsu = 0; if_took = 0; lsu_took = 0;
    for (int c = 0; c < 600; c++) begin
      if (if_took) if_req = 0;
      if (lsu_took) lsu_req = 0;
      if (!if_req && ($urandom % 3 == 0)) begin if_req = 1; if_addr = $urandom; end
      if (!lsu_req && ($urandom % 3 == 0)) begin
        lsu_req = 1; lsu_we = $urandom; lsu_be = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom;
      end
      mem_gnt = $urandom; mem_rvalid = ($urandom % 3 == 0); mem_rdata = $urandom;
      settle();
      // One transaction in flight: it is either waiting for memory gnt or for its response.
      exp_req = cur.valid && !cur.mem_acc;
      resp    = cur.valid && cur.mem_acc && mem_rvalid;
      free    = !cur.valid || resp;
      w_lsu   = free && lsu_req && (!if_req || !RoundRobin || !last_lsu);
      w_if    = free && if_req && !w_lsu;
      n_cmp++; if ({lsu_gnt, if_gnt} !== {w_lsu, w_if}) begin
        n_fail++; $display("FAIL rnd_gnt c%0d: got lsu=%b if=%b want lsu=%b if=%b", c, lsu_gnt, if_gnt, w_lsu, w_if);
      end
      n_cmp++; if ({lsu_rvalid, if_rvalid} !== {resp && cur.lsu, resp && !cur.lsu}) begin
        n_fail++; $display("FAIL rnd_rvalid c%0d: got lsu=%b if=%b want lsu=%b if=%b", c, lsu_rvalid, if_rvalid, resp && cur.lsu, resp && !cur.lsu);
      end
      n_cmp++; if (mem_req !== exp_req) begin n_fail++; $display("FAIL rnd_req c%0d: got %b want %b", c, mem_req, exp_req); end
      if (exp_req) begin
        n_cmp++; if ({mem_addr, mem_we, mem_be} !== {cur.addr, cur.we, cur.be}) begin
          n_fail++; $display("FAIL rnd_cmd c%0d: got addr=%h we=%b be=%h want addr=%h we=%b be=%h", c, mem_addr, mem_we, mem_be, cur.addr, cur.we, cur.be);
        end
        if (cur.lsu) begin
          n_cmp++; if (mem_wdata !== cur.wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, cur.wdata); end
        end
      end
      if (resp) begin
        n_cmp++; if ((cur.lsu ? lsu_rdata : if_rdata) !== mem_rdata) begin
          n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, cur.lsu ? lsu_rdata : if_rdata, mem_rdata);
        end
      end
      if (resp) cur.valid = 0;
      else if (exp_req && mem_gnt) cur.mem_acc = 1;
      if (w_lsu) cur = '{1, 1, 0, lsu_addr, lsu_we, lsu_be, lsu_wdata};
      if (w_if) cur = '{1, 0, 0, if_addr, 1'b0, 4'hF, 32'h0};
      if (w_lsu || w_if) last_lsu = w_lsu;
      if_took = w_if; lsu_took = w_lsu;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_stall();
    test_spurious();
    test_reset_mid();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the load/store path (LSU).
- Accepts one request per requester side, issues it downstream with a req/gnt handshake, waits for the response, and routes rdata/rvalid back to the owner.
- Exactly one transaction outstanding. Sits between the fetch/LSU logic and the memory interface, feeding the register-file write-back mux via the LSU read-data path.

Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- if_req_i  in  1  fetch request, held until if_gnt_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  DATA_WIDTH  fetch data
- lsu_req_i  in  1  LSU request, held until lsu_gnt_o
- lsu_we_i  in  1  1 = store
- lsu_be_i  in  BE_WIDTH  byte enables
- lsu_addr_i  in  ADDR_WIDTH  LSU address
- lsu_wdata_i  in  DATA_WIDTH  store data
- lsu_gnt_o  out  1  LSU request accepted (1-cycle pulse)
- lsu_rvalid_o  out  1  LSU response valid (loads and stores)
- lsu_rdata_o  out  DATA_WIDTH  load data
- mem_req_o  out  1  downstream request
- mem_we_o  out  1  downstream write enable
- mem_be_o  out  BE_WIDTH  downstream byte enables
- mem_addr_o  out  ADDR_WIDTH  downstream address
- mem_wdata_o  out  DATA_WIDTH  downstream write data
- mem_gnt_i  in  1  downstream accepted request
- mem_rvalid_i  in  1  downstream response valid
- mem_rdata_i  in  DATA_WIDTH  downstream read data

Behaviour:
- Clocking and reset
  - One clock, clk_i. Reset is asynchronous and active-high on rst_i.
  - On reset: state = IDLE, owner = IF, all mem_* registers = 0, all *_gnt_o and *_rvalid_o = 0.
- FSM states: IDLE, ISSUE, WAIT_RSP.
- Arbitration
  - Runs combinationally in IDLE, and in WAIT_RSP in the cycle mem_rvalid_i = 1.
  - Winner: LSU if lsu_req_i, else IF if if_req_i (fixed priority; see optional feature).
- Acceptance
  - When a winner exists, that requester's gnt_o pulses high for that cycle.
  - On the same edge: request is latched into the mem_* output registers, owner is recorded, next state = ISSUE.
  - IF requests latch we = 0 and be = all ones.
  - The loser sees no gnt and keeps its req high.
- ISSUE
  - mem_req_o = 1 with stable latched address, we, be and wdata.
  - On mem_gnt_i = 1: next state = WAIT_RSP and mem_req_o deasserts on the next cycle.
  - No timeout; ISSUE holds indefinitely without gnt.
- WAIT_RSP
  - mem_req_o = 0.
  - On mem_rvalid_i = 1: owner's rvalid_o = 1 combinationally in the same cycle.
  - Then re-arbitrate: winner goes to ISSUE, otherwise IDLE.
- Read data
  - if_rdata_o and lsu_rdata_o are both driven directly from mem_rdata_i.
  - Only the owner's rvalid qualifies the data.
- Latency (zero-wait memory)
  - Request accepted in cycle N, mem_req_o in N+1, gnt in N+1, rvalid in N+2.
  - Back-to-back throughput: one transaction per 2 cycles.
- Boundary conditions
  - mem_rvalid_i in IDLE or ISSUE: ignored, no rvalid to any requester.
  - mem_gnt_i outside ISSUE: ignored.
  - Both requests in the same cycle: exactly one gnt.
- Reset mid-transaction: immediate return to IDLE, mem_req_o = 0. A later response for the aborted transaction is dropped per the rule above.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a last-granted flop (reset = IF) is added. When both requesters are active, the side not granted last wins. A single active requester always wins.
- Not defined: fixed LSU-over-IF priority, no extra flop.

Test Plan:
- Single fetch: if_req_i = 1, if_addr_i = 0x0000_0100, gnt and rvalid zero-wait.
  - Required: if_gnt_o pulse in cycle 0; mem_addr_o = 0x100, mem_we_o = 0, mem_be_o = 0xF in cycle 1; mem_rdata_i = 0xDEADBEEF gives if_rvalid_o = 1 and if_rdata_o = 0xDEADBEEF in cycle 2; lsu_rvalid_o stays 0.
- Simultaneous requests, fixed priority: IF addr 0x100 and LSU store addr 0x2000, wdata 0x1234_5678, be 0x3, both held.
  - Required: LSU granted first with mem_we_o = 1 and mem_be_o = 0x3.
  - IF granted in the LSU rvalid cycle and issued next.
- Round robin (MEM_ARB_ROUND_ROBIN_EN defined): both requests held continuously for 4 transactions.
  - Required grant order: LSU, IF, LSU, IF (last-granted resets to IF).
- Downstream stall: mem_gnt_i held 0 for 5 cycles.
  - Required: mem_req_o and address stable for all 5 cycles, and no new gnt to either requester.
- Spurious response: mem_rvalid_i = 1 while in IDLE.
  - Required: no rvalid to either side and state unchanged.
- Reset mid-transaction: rst_i pulsed during WAIT_RSP, then mem_rvalid_i = 1 one cycle after release.
  - Required: mem_req_o = 0 immediately on reset, and both rvalid outputs stay 0.
